poolb_dp_gen: RTL and testbench

//  Parametrised N-channel 2x2/stride-2 pooling datapath for the pool-B stage; successor to the fixed 3-unit pool datapath.

---
 rtl/poolb_dp_gen.sv | 151 +++++++++++++++
 tb/tb_poolb_dp_gen.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poolb_dp_gen.sv
// poolb_dp_gen: N-channel 2x2/stride-2 pooling datapath (max or average).
// Ports:
//   clk, reset (async, active-low), clear (sync flush)
//   in_valid/in_ready with in_a (row 2r), in_b (row 2r+1), NUM_CH lanes of DATA_WIDTH bits
//   out_valid/out_ready with out_data (same packing), out_last (final output of the layer)
// Build option: define POOLB_RELU_EN to clamp negative results to zero.
module poolb_dp_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_SIZE   = 10,
    parameter int IFM_DEPTH  = 30,
    parameter int NUM_CH     = 3,
    parameter int POOL_MODE  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_a,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         out_last
);

    localparam int DW     = DATA_WIDTH;
    localparam int PW     = DW + 2;
    localparam int ROWS   = IFM_SIZE / 2;
    localparam int GROUPS = (IFM_DEPTH + NUM_CH - 1) / NUM_CH;
    localparam int CW     = $clog2(IFM_SIZE);
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [CW-1:0] COL_MAX   = CW'(IFM_SIZE - 1);
    localparam logic [CW-1:0] PCOL_LAST = CW'(2 * ROWS - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
    localparam logic [GW-1:0] GRP_MAX   = GW'(GROUPS - 1);
    localparam bit            ODD_SIZE  = (IFM_SIZE % 2) != 0;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [GW-1:0] grp_q, grp_d;

    logic signed [PW-1:0] part_q [NUM_CH];
    logic signed [PW-1:0] pnext_w [NUM_CH];

    logic                   out_valid_q;
    logic                   out_last_q;
    logic [NUM_CH*DW-1:0]   out_data_q;
    logic [NUM_CH*DW-1:0]   res_flat;

    logic accept, drop_beat, odd_beat, even_beat, last_d;

    assign in_ready  = reset & (out_ready | ~out_valid_q);
    assign accept    = in_valid & in_ready & ~clear;
    // With an odd map size the trailing column has no partner.
    assign drop_beat = ODD_SIZE && (col_q == COL_MAX);
    assign odd_beat  = accept & col_q[0];
    assign even_beat = accept & ~col_q[0] & ~drop_beat;
    assign last_d    = (col_q == PCOL_LAST) && (row_q == ROW_MAX)
                    && (grp_q == GRP_MAX);

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        grp_d = grp_q;
        if (col_q == COL_MAX) begin
            col_d = '0;
            if (row_q == ROW_MAX) begin
                row_d = '0;
                grp_d = (grp_q == GRP_MAX) ? '0 : grp_q + 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [DW-1:0] a_s, b_s, raw, res;

        assign a_s = in_a[k*DW +: DW];
        assign b_s = in_b[k*DW +: DW];

        if (POOL_MODE == 1) begin : g_avg
            logic signed [PW-1:0] s2, s3;
            logic [1:0]           unused_frac;
            assign s2 = {{2{a_s[DW-1]}}, a_s} + {{2{b_s[DW-1]}}, b_s};
            assign s3 = part_q[k] + s2;
            // Dropping the two LSBs of a signed sum is floor(sum/4).
            assign raw = s3[DW+1:2];
            assign unused_frac = s3[1:0];
            assign pnext_w[k] = s2;
        end else begin : g_max
            logic signed [DW-1:0] mx2, pm;
            logic [1:0]           unused_hi;
            assign mx2 = (a_s > b_s) ? a_s : b_s;
            assign pm  = part_q[k][DW-1:0];
            assign raw = (pm > mx2) ? pm : mx2;
            assign unused_hi = part_q[k][PW-1:DW];
            assign pnext_w[k] = {{2{mx2[DW-1]}}, mx2};
        end

`ifdef POOLB_RELU_EN
        assign res = raw[DW-1] ? '0 : raw;
`else
        assign res = raw;
`endif
        assign res_flat[k*DW +: DW] = res;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q       <= '0;
            row_q       <= '0;
            grp_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) part_q[k] <= '0;
        end else if (clear) begin
            col_q       <= '0;
            row_q       <= '0;
            grp_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) part_q[k] <= '0;
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
                grp_q <= grp_d;
            end
            if (odd_beat) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_flat;
                out_last_q  <= last_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (even_beat) part_q[k] <= pnext_w[k];
            end
        end
    end

endmodule

// File: tb/tb_poolb_dp_gen.sv
// Bench for poolb_dp_gen: max DUT with a scoreboard, average DUT
// (odd 3x3 maps, one lane) driven from a vector table.
module tb_poolb_dp_gen;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready;
    logic [95:0] in_a, in_b, out_data;
    logic        out_valid, out_ready, out_last;

    logic        av_in_valid, av_in_ready, av_out_valid, av_out_last;
    logic [31:0] av_in_a, av_in_b, av_out_data;
    logic        av_clear = 1'b0;
    logic        av_out_ready = 1'b1;

    always #5 clk = ~clk;

    poolb_dp_gen dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    poolb_dp_gen #(
        .DATA_WIDTH(32), .IFM_SIZE(3), .IFM_DEPTH(2),
        .NUM_CH(1), .POOL_MODE(1)
    ) dut_avg (
        .clk(clk), .reset(reset), .clear(av_clear),
        .in_valid(av_in_valid), .in_ready(av_in_ready),
        .in_a(av_in_a), .in_b(av_in_b),
        .out_valid(av_out_valid), .out_ready(av_out_ready),
        .out_data(av_out_data), .out_last(av_out_last)
    );

    typedef struct packed {
        logic [95:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        int a0, b0, a1, b1, exp;
        bit last;
    } avec_t;

    exp_t  q[$];
    avec_t tab[6];
    int    tests = 0, errs = 0;
    int    n_out = 0, n_last = 0;
    int    bp_mode = 0;
    int    m_col, m_row, m_grp;
    logic signed [31:0] m_part[3];

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chk(name, {64'd0, act}, {64'd0, exp});
    endtask

    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [31:0] relu(input logic signed [31:0] v);
`ifdef POOLB_RELU_EN
        return (v < 0) ? 32'sd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        m_grp = 0;
        for (int k = 0; k < 3; k++) m_part[k] = 0;
    endtask

    task automatic model_beat(input logic [95:0] a, input logic [95:0] b);
        logic [95:0]        d;
        logic signed [31:0] x;
        d = '0;
        for (int k = 0; k < 3; k++) begin
            x = smax(a[k*32 +: 32], b[k*32 +: 32]);
            if (m_col % 2 == 0) m_part[k] = x;
            else d[k*32 +: 32] = relu(smax(m_part[k], x));
        end
        if (m_col % 2 == 1)
            q.push_back('{d, (m_col == 9 && m_row == 4 && m_grp == 9)});
        m_col++;
        if (m_col == 10) begin
            m_col = 0;
            m_row++;
            if (m_row == 5) begin
                m_row = 0;
                m_grp = (m_grp == 9) ? 0 : m_grp + 1;
            end
        end
    endtask

    task automatic beat(input logic [95:0] a, input logic [95:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            errs++;
            $display("FAIL beat_timeout: in_ready stuck at 0, required 1");
        end else begin
            model_beat(a, b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #3;
            if (q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            errs++;
            $display("FAIL drain_timeout: %0d outputs pending, required 0",
                     q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear(input bit with_beat);
        clear = 1'b1;
        in_valid = with_beat;
        in_a = rnd96();
        in_b = rnd96();
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        q.delete();
        model_reset();
    endtask

    task automatic av_beat(input int a, input int b);
        av_in_valid = 1'b1;
        av_in_a = a;
        av_in_b = b;
        @(negedge clk);
        chk("avg_in_ready", av_in_ready, 1'b1);
        @(posedge clk);
        #1;
        av_in_valid = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = $urandom_range(0, 1) == 1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        exp_t e;
        bit   hold_prev;
        logic [95:0] hold_data;
        hold_prev = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (reset && hold_prev) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, hold_data);
            end
            if (reset && !clear && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    errs++;
                    $display("FAIL extra_output: got %h, required none",
                             out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    n_out++;
                    if (out_last) n_last++;
                end
            end
            hold_prev = reset && !clear && out_valid && !out_ready;
            hold_data = out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] held;
        logic [95:0] a, b;

        tab[0] = '{-3, -4, -2, -2, -3, 1'b0};
        tab[1] = '{4, 4, 4, 3, 3, 1'b1};
        tab[2] = '{2147483647, 2147483647, 2147483647, 2147483647,
                   2147483647, 1'b0};
        tab[3] = '{int'(32'h80000000), int'(32'h80000000),
                   int'(32'h80000000), int'(32'h80000000),
                   int'(32'h80000000), 1'b1};
        tab[4] = '{-1, 0, 0, 0, -1, 1'b0};
        tab[5] = '{5, 6, 7, 8, 6, 1'b1};

        reset = 1'b0;
        clear = 1'b0;
        in_valid = 1'b1;
        in_a = rnd96();
        in_b = rnd96();
        av_in_valid = 1'b1;
        av_in_a = 0;
        av_in_b = 0;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, 96'd0);
            chk("rst_out_last", out_last, 1'b0);
            chk("rst_avg_valid", av_out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        av_in_valid = 1'b0;

        // Max pair on ch0, then finish the row pair: 5 outputs expected.
        n_out = 0;
        beat({$urandom, $urandom, 32'd1}, {$urandom, $urandom, 32'd5});
        beat({$urandom, $urandom, 32'd7}, {$urandom, $urandom, -32'sd2});
        chk("max_valid", out_valid, 1'b1);
        chk32("max_ch0", out_data[31:0], 32'd7);
        for (int i = 0; i < 8; i++) beat(rnd96(), rnd96());
        drain(50);
        chk("row_outputs", n_out, 5);

        // Output held under backpressure while the next beat waits.
        bp_mode = 2;
        beat(rnd96(), rnd96());
        beat(rnd96(), rnd96());
        fork
            beat(rnd96(), rnd96());
            begin
                @(negedge clk);
                held = out_data;
                repeat (4) begin
                    chk("bp_in_ready", in_ready, 1'b0);
                    chk("bp_out_valid", out_valid, 1'b1);
                    chk("bp_stable", out_data, held);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bp_mode = 0;
            end
        join
        beat(rnd96(), rnd96());
        drain(50);

        // clear flushes a pending output and drops the offered beat.
        bp_mode = 2;
        beat(rnd96(), rnd96());
        beat(rnd96(), rnd96());
        @(negedge clk);
        chk("clr_pending", out_valid, 1'b1);
        @(posedge clk);
        #1;
        pulse_clear(1'b1);
        chk("clr_flush", out_valid, 1'b0);
        bp_mode = 0;
        beat({$urandom, $urandom, 32'd100}, {$urandom, $urandom, 32'd100});
        pulse_clear(1'b1);
        chk("clr_midrow", out_valid, 1'b0);
        beat({$urandom, $urandom, -32'sd5}, {$urandom, $urandom, -32'sd9});
        beat({$urandom, $urandom, -32'sd1}, {$urandom, $urandom, -32'sd7});
        chk("clr_pair_valid", out_valid, 1'b1);
        chk32("clr_pair_ch0", out_data[31:0], relu(-32'sd1));
        drain(50);

        // Whole frame under random backpressure.
        pulse_clear(1'b0);
        n_out = 0;
        n_last = 0;
        bp_mode = 1;
        for (int i = 0; i < 500; i++) beat(rnd96(), rnd96());
        drain(400);
        chk("frame_outputs", n_out, 250);
        chk("frame_lasts", n_last, 1);
        bp_mode = 0;
        n_last = 0;
        n_out = 0;
        beat(rnd96(), rnd96());
        beat(rnd96(), rnd96());
        drain(50);
        chk("wrap_outputs", n_out, 1);
        chk("wrap_no_last", n_last, 0);

        // Reset mid-row restarts the frame at column 0.
        beat({$urandom, $urandom, 32'd50}, {$urandom, $urandom, 32'd50});
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_ready", in_ready, 1'b0);
            chk("mid_rst_valid", out_valid, 1'b0);
            chk("mid_rst_data", out_data, 96'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        model_reset();
        a = {$urandom, $urandom, -32'sd8};
        b = {$urandom, $urandom, -32'sd20};
        beat(a, b);
        beat({$urandom, $urandom, -32'sd3}, {$urandom, $urandom, -32'sd4});
        chk32("mid_rst_ch0", out_data[31:0], relu(-32'sd3));
        drain(50);

        // Average lane, 3x3 maps: pair then a discarded column.
        for (int i = 0; i < 6; i++) begin
            av_beat(tab[i].a0, tab[i].b0);
            av_beat(tab[i].a1, tab[i].b1);
            chk("avg_valid", av_out_valid, 1'b1);
            chk32("avg_data", av_out_data, relu(tab[i].exp));
            chk("avg_last", av_out_last, tab[i].last);
            av_beat($urandom, $urandom);
            chk("avg_drop", av_out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
